// File: rtl/qsch.sv
// Per-port queue scheduler: picks one MB queue per transmission, pops its head,
// issues the metadata to the transmit engine and waits for completion.
module qsch #(
  parameter logic [15:0] TICK_CYCLES = 16'd125,
  parameter logic [15:0] TOKEN_INC   = 16'd125,
  parameter logic [15:0] BUCKET_MAX  = 16'd3000,
  parameter logic [15:0] TX_TIMEOUT  = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_qsch_time_slot_flag,
  input  logic [3:0]  in_qsch_q_empty,
  input  logic [8:0]  in_qsch_q0_md,
  input  logic [8:0]  in_qsch_q1_md,
  input  logic [19:0] in_qsch_q2_md,
  input  logic [8:0]  in_qsch_q3_md,
  input  logic        in_qsch_tx_done,
  output logic [3:0]  out_qsch_q_rd,
  output logic [8:0]  out_qsch_md,
  output logic        out_qsch_md_wr,
  output logic [1:0]  out_qsch_qid,
  output logic        out_qsch_busy,
  output logic        out_qsch_timeout,
  output logic [15:0] out_qsch_tokens
);

  // state     | meaning
  // S_IDLE    | evaluate eligible queues each cycle
  // S_ISSUE   | pop winner, emit md, charge q2 tokens
  // S_WAIT    | wait for tx_done or timeout
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_id_q, sel_id_d;
  logic [8:0]  md_q, md_d;
  logic [10:0] len_q, len_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] tokens_q, tokens_d;

  logic        tsn_ok, q2_ok, q3_ok, win_any;
  logic [1:0]  win_id;
  logic [8:0]  win_md;
  logic [10:0] q2_len;
  logic        tick, to_hit;
  logic [16:0] sum17, consume17, diff17;

  assign q2_len = in_qsch_q2_md[19:9];
  assign tsn_ok = in_qsch_time_slot_flag ? ~in_qsch_q_empty[0] : ~in_qsch_q_empty[1];
  assign q2_ok  = ~in_qsch_q_empty[2] &&
                  ((q2_len == 11'd0) || (tokens_q >= {5'd0, q2_len}));
  assign q3_ok  = ~in_qsch_q_empty[3];
  assign win_any = tsn_ok || q2_ok || q3_ok;

  always_comb begin
    win_id = 2'd3;
    win_md = in_qsch_q3_md;
    if (tsn_ok) begin
      win_id = in_qsch_time_slot_flag ? 2'd0 : 2'd1;
      win_md = in_qsch_time_slot_flag ? in_qsch_q0_md : in_qsch_q1_md;
    end else if (q2_ok) begin
      win_id = 2'd2;
      win_md = in_qsch_q2_md[8:0];
    end
  end

  assign tick   = (tick_cnt_q == TICK_CYCLES - 16'd1);
  assign to_hit = (state_q == S_WAIT) && (to_cnt_q == TX_TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_any) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (in_qsch_tx_done || to_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_qsch_q_rd    = 4'b0000;
    out_qsch_md_wr   = 1'b0;
    out_qsch_busy    = (state_q != S_IDLE);
    out_qsch_timeout = to_hit && !in_qsch_tx_done;
    if (state_q == S_ISSUE) begin
      out_qsch_q_rd  = 4'b0001 << sel_id_q;
      out_qsch_md_wr = 1'b1;
    end
  end

  assign out_qsch_md     = md_q;
  assign out_qsch_qid    = sel_id_q;
  assign out_qsch_tokens = tokens_q;

  // Winner latch, tick/timeout counters and token bucket.
  always_comb begin
    sel_id_d   = sel_id_q;
    md_d       = md_q;
    len_d      = len_q;
    if (state_q == S_IDLE && win_any) begin
      sel_id_d = win_id;
      md_d     = win_md;
      len_d    = (win_id == 2'd2) ? q2_len : 11'd0;
    end
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    to_cnt_d   = (state_q == S_WAIT) ? to_cnt_q + 16'd1 : 16'd0;

    sum17     = {1'b0, tokens_q} + (tick ? {1'b0, TOKEN_INC} : 17'd0);
    consume17 = (state_q == S_ISSUE && sel_id_q == 2'd2) ? {6'd0, len_q} : 17'd0;
    diff17    = (sum17 < consume17) ? 17'd0 : sum17 - consume17;
    tokens_d  = (diff17 > {1'b0, BUCKET_MAX}) ? BUCKET_MAX : diff17[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_id_q   <= 2'd0;
      md_q       <= 9'd0;
      len_q      <= 11'd0;
      tick_cnt_q <= 16'd0;
      to_cnt_q   <= 16'd0;
      tokens_q   <= BUCKET_MAX;
    end else begin
      sel_id_q   <= sel_id_d;
      md_q       <= md_d;
      len_q      <= len_d;
      tick_cnt_q <= tick_cnt_d;
      to_cnt_q   <= to_cnt_d;
      tokens_q   <= tokens_d;
    end
  end

endmodule

// File: tb/tb_qsch.sv
// Directed bench for qsch: slot gating, priority, token bucket, timeout, reset.
module tb_qsch;
  localparam logic [15:0] TICK = 16'd1000;
  localparam logic [15:0] INC  = 16'd125;
  localparam logic [15:0] BMAX = 16'd3000;
  localparam logic [15:0] TOUT = 16'd64;

  logic        clk, rst_n, slot, tx_done;
  logic [3:0]  empty;
  logic [8:0]  q0_md, q1_md, q3_md;
  logic [19:0] q2_md;
  logic [3:0]  q_rd;
  logic [8:0]  md;
  logic        md_wr, busy, tmo;
  logic [1:0]  qid;
  logic [15:0] tokens;

  int cyc = 0, nvec = 0, nerr = 0;

  qsch #(.TICK_CYCLES(TICK), .TOKEN_INC(INC), .BUCKET_MAX(BMAX), .TX_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_qsch_time_slot_flag(slot), .in_qsch_q_empty(empty),
    .in_qsch_q0_md(q0_md), .in_qsch_q1_md(q1_md), .in_qsch_q2_md(q2_md), .in_qsch_q3_md(q3_md),
    .in_qsch_tx_done(tx_done),
    .out_qsch_q_rd(q_rd), .out_qsch_md(md), .out_qsch_md_wr(md_wr), .out_qsch_qid(qid),
    .out_qsch_busy(busy), .out_qsch_timeout(tmo), .out_qsch_tokens(tokens)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    logic [3:0] rd_seen;
    logic       to_seen, got;
    int         ticks, e_cyc, i_cyc;
    logic [15:0] prev;

    rst_n = 1'b0; slot = 1'b0; tx_done = 1'b0; empty = 4'hF;
    q0_md = 9'h0; q1_md = 9'h0; q2_md = 20'h0; q3_md = 9'h0;
    repeat (3) step();
    chk("rst_q_rd", q_rd, 4'b0000);
    chk("rst_md_wr", md_wr, 1'b0);
    chk("rst_md", md, 9'h0);
    chk("rst_qid", qid, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", tmo, 1'b0);
    chk("rst_tokens", tokens, 16'd3000);
    rst_n = 1'b1;

    // Slot 1: q0 beats q3, then q3 follows
    slot = 1'b1; q0_md = 9'h1A5; q1_md = 9'h07E; q3_md = 9'h0C3; empty = 4'b0110;
    step();
    chk("q0_rd", q_rd, 4'b0001);
    chk("q0_md_wr", md_wr, 1'b1);
    chk("q0_md", md, 9'h1A5);
    chk("q0_qid", qid, 2'd0);
    chk("q0_busy", busy, 1'b1);
    empty = 4'b0111;
    step();
    chk("wait_rd", q_rd, 4'b0000);
    chk("wait_md_held", md, 9'h1A5);
    chk("wait_busy", busy, 1'b1);
    finish_tx();
    chk("idle_busy", busy, 1'b0);
    step();
    chk("q3_rd", q_rd, 4'b1000);
    chk("q3_qid", qid, 2'd3);
    chk("q3_md", md, 9'h0C3);
    empty = 4'hF;
    step();
    finish_tx();

    // Slot 0 blocks q0; flipping slot releases it
    slot = 1'b0; q0_md = 9'h111; empty = 4'b1110;
    rd_seen = 4'b0;
    repeat (6) begin step(); rd_seen |= q_rd; end
    chk("slot0_no_pop", rd_seen, 4'b0000);
    slot = 1'b1;
    step();
    chk("slot1_q0_rd", q_rd, 4'b0001);
    chk("slot1_q0_md", md, 9'h111);
    empty = 4'hF;
    step();
    finish_tx();

    // Two 1500-byte q2 packets drain the full bucket
    q2_md = {11'd1500, 9'h055}; empty = 4'b1011;
    step();
    chk("q2a_rd", q_rd, 4'b0100);
    chk("q2a_qid", qid, 2'd2);
    chk("q2a_md", md, 9'h055);
    chk("q2a_tok_issue", tokens, 16'd3000);
    step();
    chk("q2a_tok_after", tokens, 16'd1500);
    q2_md = {11'd1500, 9'h056};
    finish_tx();
    step();
    chk("q2b_rd", q_rd, 4'b0100);
    chk("q2b_md", md, 9'h056);
    step();
    chk("q2b_tok_after", tokens, 16'd0);
    q2_md = {11'd1500, 9'h057};
    finish_tx();

    // Third packet waits for 12 refills
    ticks = 0; got = 1'b0; prev = tokens;
    for (int i = 0; i < 20000 && !got; i++) begin
      step();
      if (tokens > prev) ticks++;
      prev = tokens;
      if (q_rd == 4'b0100) got = 1'b1;
    end
    chk("q2c_issued", got, 1'b1);
    chk("q2c_ticks", ticks, 12);
    chk("q2c_tok_issue", tokens, 16'd1500);
    chk("q2c_md", md, 9'h057);
    e_cyc = cyc - 1;
    empty = 4'hF;
    step();
    chk("q2c_tok_after", tokens, 16'd0);
    finish_tx();

    // PTP (len 0) passes with empty bucket
    q2_md = {11'd0, 9'h1FF}; empty = 4'b1011;
    step();
    chk("ptp_rd", q_rd, 4'b0100);
    chk("ptp_md", md, 9'h1FF);
    empty = 4'hF;
    step();
    chk("ptp_tok", tokens, 16'd0);
    finish_tx();

    // ISSUE cycle lands on a tick edge: 125 + 125 - 100
    q2_md = {11'd100, 9'h0AA};
    while (cyc < e_cyc + 1998) step();
    chk("tc_tok_pre", tokens, 16'd125);
    empty = 4'b1011;
    step();
    chk("tc_rd", q_rd, 4'b0100);
    chk("tc_tok_issue", tokens, 16'd125);
    empty = 4'hF;
    step();
    chk("tc_tok_after", tokens, 16'd150);
    finish_tx();

    // Timeout with no tx_done
    q3_md = 9'h033; empty = 4'b0111;
    step();
    chk("to_rd", q_rd, 4'b1000);
    empty = 4'hF; i_cyc = cyc; to_seen = 1'b0;
    while (cyc < i_cyc + 63) begin step(); to_seen |= tmo; end
    chk("to_early", to_seen, 1'b0);
    step();
    chk("to_pulse", tmo, 1'b1);
    chk("to_busy_exit", busy, 1'b1);
    step();
    chk("to_pulse_end", tmo, 1'b0);
    chk("to_idle", busy, 1'b0);

    // tx_done on the timeout cycle wins
    empty = 4'b0111;
    step();
    empty = 4'hF; i_cyc = cyc;
    while (cyc < i_cyc + 64) step();
    tx_done = 1'b1;
    #1;
    chk("done_vs_to", tmo, 1'b0);
    step();
    tx_done = 1'b0;
    chk("done_vs_to_idle", busy, 1'b0);

    // Reset during WAIT_DONE
    q3_md = 9'h0F0; empty = 4'b0111;
    step();
    chk("mr_qid", qid, 2'd3);
    empty = 4'hF;
    step();
    rst_n = 1'b0;
    step();
    chk("mr_q_rd", q_rd, 4'b0000);
    chk("mr_md_wr", md_wr, 1'b0);
    chk("mr_md", md, 9'h0);
    chk("mr_qid0", qid, 2'd0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_timeout", tmo, 1'b0);
    chk("mr_tokens", tokens, 16'd3000);
    rst_n = 1'b1;
    rd_seen = 4'b0;
    repeat (3) begin step(); rd_seen |= q_rd; end
    chk("mr_no_pop", rd_seen, 4'b0000);

    // Refill 2900 + 125 clamps at the ceiling
    q2_md = {11'd100, 9'h0AA}; empty = 4'b1011;
    step();
    chk("cl_rd", q_rd, 4'b0100);
    empty = 4'hF;
    step();
    chk("cl_tok_after", tokens, 16'd2900);
    finish_tx();
    for (int i = 0; i < 1500 && tokens == 16'd2900; i++) step();
    chk("cl_tok_clamp", tokens, 16'd3000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
